// File: rtl/mult_share_arbiter.sv
// Two-requester round-robin front end for one shared N_BITS x N_BITS multiplier.
// Operands are registered toward the multiplier; the product is sampled after MUL_LAT.
module mult_share_arbiter #(
    parameter int N_BITS  = 4,
    parameter int MUL_LAT = 1
) (
    input  logic                  clk_100M,
    input  logic                  rst,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [N_BITS-1:0]     req0_a,
    input  logic [N_BITS-1:0]     req0_b,
    output logic                  resp0_valid,
    input  logic                  resp0_ready,
    output logic [2*N_BITS-1:0]   resp0_c,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [N_BITS-1:0]     req1_a,
    input  logic [N_BITS-1:0]     req1_b,
    output logic                  resp1_valid,
    input  logic                  resp1_ready,
    output logic [2*N_BITS-1:0]   resp1_c,
    output logic [N_BITS-1:0]     mul_a,
    output logic [N_BITS-1:0]     mul_b,
    input  logic [2*N_BITS-1:0]   mul_c,
    output logic                  busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                prio_q, prio_d;
    logic                gnt_q, gnt_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [N_BITS-1:0]   mul_a_q, mul_a_d;
    logic [N_BITS-1:0]   mul_b_q, mul_b_d;
    logic [2*N_BITS-1:0] resp0_c_q, resp0_c_d;
    logic [2*N_BITS-1:0] resp1_c_q, resp1_c_d;
    logic                winner;
    logic                resp_rdy_g;

    // Handshake decode: winner is the lone valid requester, or prio on a tie
    always_comb begin
        winner     = (req0_valid && req1_valid) ? prio_q : req1_valid;
        req0_ready = !rst && (state_q == IDLE) && req0_valid && !winner;
        req1_ready = !rst && (state_q == IDLE) && req1_valid && winner;
        resp_rdy_g = gnt_q ? resp1_ready : resp0_ready;
    end

    assign resp0_valid = (state_q == RESP) && !gnt_q;
    assign resp1_valid = (state_q == RESP) && gnt_q;
    assign busy        = (state_q != IDLE);
    assign mul_a       = mul_a_q;
    assign mul_b       = mul_b_q;
    assign resp0_c     = resp0_c_q;
    assign resp1_c     = resp1_c_q;

    // Next-state: accept, count down the multiplier latency, hold the response
    always_comb begin
        state_d   = state_q;
        prio_d    = prio_q;
        gnt_d     = gnt_q;
        cnt_d     = cnt_q;
        mul_a_d   = mul_a_q;
        mul_b_d   = mul_b_q;
        resp0_c_d = resp0_c_q;
        resp1_c_d = resp1_c_q;
        unique case (state_q)
            IDLE: begin
                if (req0_ready) begin
                    mul_a_d = req0_a;
                    mul_b_d = req0_b;
                    gnt_d   = 1'b0;
                    cnt_d   = 4'(MUL_LAT);
                    state_d = WAIT;
                end else if (req1_ready) begin
                    mul_a_d = req1_a;
                    mul_b_d = req1_b;
                    gnt_d   = 1'b1;
                    cnt_d   = 4'(MUL_LAT);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    if (gnt_q) resp1_c_d = mul_c;
                    else       resp0_c_d = mul_c;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (resp_rdy_g) begin
                    prio_d  = ~gnt_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register with synchronous reset
    always_ff @(posedge clk_100M) begin
        if (rst) begin
            state_q   <= IDLE;
            prio_q    <= 1'b0;
            gnt_q     <= 1'b0;
            cnt_q     <= '0;
            mul_a_q   <= '0;
            mul_b_q   <= '0;
            resp0_c_q <= '0;
            resp1_c_q <= '0;
        end else begin
            state_q   <= state_d;
            prio_q    <= prio_d;
            gnt_q     <= gnt_d;
            cnt_q     <= cnt_d;
            mul_a_q   <= mul_a_d;
            mul_b_q   <= mul_b_d;
            resp0_c_q <= resp0_c_d;
            resp1_c_q <= resp1_c_d;
        end
    end

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Bench for mult_share_arbiter: directed scenarios then random traffic,
// checked every cycle against a transaction-level reference model.
module tb_mult_share_arbiter;

    localparam int LAT = 1;

    logic       clk_100M = 1'b0;
    logic       rst = 1'b1;
    logic       req0_valid = 1'b0, req1_valid = 1'b0;
    logic       req0_ready, req1_ready;
    logic [3:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic       resp0_valid, resp1_valid;
    logic       resp0_ready = 1'b0, resp1_ready = 1'b0;
    logic [7:0] resp0_c, resp1_c;
    logic [3:0] mul_a, mul_b;
    logic [7:0] mul_c;
    logic       busy;

    always #5 clk_100M = ~clk_100M;

    mult_share_arbiter #(.N_BITS(4), .MUL_LAT(LAT)) dut (
        .clk_100M(clk_100M), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b),
        .resp0_valid(resp0_valid), .resp0_ready(resp0_ready),
        .resp0_c(resp0_c),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b),
        .resp1_valid(resp1_valid), .resp1_ready(resp1_ready),
        .resp1_c(resp1_c),
        .mul_a(mul_a), .mul_b(mul_b), .mul_c(mul_c), .busy(busy)
    );

    // Shared multiplier model with LAT register stages
    if (LAT == 0) begin : g_comb
        assign mul_c = 8'(mul_a) * 8'(mul_b);
    end else begin : g_pipe
        logic [7:0] mp [LAT];
        always_ff @(posedge clk_100M) begin
            mp[0] <= 8'(mul_a) * 8'(mul_b);
            for (int i = 1; i < LAT; i++) mp[i] <= mp[i-1];
        end
        assign mul_c = mp[LAT-1];
    end

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: at most one pending op, stamped with its accept edge
    int         cyc = 0;
    logic       pend = 1'b0;
    logic       pw = 1'b0;
    logic [7:0] pprod = '0;
    int         acc = 0;
    logic       prio = 1'b0;
    logic [7:0] last0 = '0, last1 = '0;
    logic [3:0] ma = '0, mb = '0;
    int         gq[$];

    task automatic step(input logic rs,
                        input logic v0, input logic [3:0] a0, input logic [3:0] b0,
                        input logic v1, input logic [3:0] a1, input logic [3:0] b1,
                        input logic r0, input logic r1);
        logic rdy0, rdy1, rv;
        rst = rs;
        req0_valid = v0; req0_a = a0; req0_b = b0;
        req1_valid = v1; req1_a = a1; req1_b = b1;
        resp0_ready = r0; resp1_ready = r1;
        #1;
        rdy0 = !rs && !pend && v0 && (!v1 || !prio);
        rdy1 = !rs && !pend && v1 && (!v0 || prio);
        rv   = pend && (cyc >= acc + LAT + 1);
        chk("req0_ready", req0_ready, rdy0);
        chk("req1_ready", req1_ready, rdy1);
        chk("busy", busy, pend);
        chk("resp0_valid", resp0_valid, rv && !pw);
        chk("resp1_valid", resp1_valid, rv && pw);
        chk("resp0_c", resp0_c, (rv && !pw) ? pprod : last0);
        chk("resp1_c", resp1_c, (rv && pw) ? pprod : last1);
        chk("mul_a", mul_a, ma);
        chk("mul_b", mul_b, mb);
        @(posedge clk_100M);
        cyc++;
        if (rs) begin
            pend = 1'b0; prio = 1'b0;
            last0 = '0; last1 = '0; ma = '0; mb = '0;
        end else if (!pend) begin
            if (rdy0 || rdy1) begin
                pend  = 1'b1;
                pw    = rdy1;
                ma    = rdy1 ? a1 : a0;
                mb    = rdy1 ? b1 : b0;
                pprod = 8'(ma) * 8'(mb);
                acc   = cyc;
                gq.push_back(int'(pw));
            end
        end else if (rv && (pw ? r1 : r0)) begin
            pend = 1'b0;
            if (pw) last1 = pprod;
            else    last0 = pprod;
            prio = ~pw;
        end
        @(negedge clk_100M);
    endtask

    task automatic run(input int n, input logic rs,
                       input logic v0, input logic [3:0] a0, input logic [3:0] b0,
                       input logic v1, input logic [3:0] a1, input logic [3:0] b1,
                       input logic r0, input logic r1);
        for (int k = 0; k < n; k++) step(rs, v0, a0, b0, v1, a1, b1, r0, r1);
    endtask

    initial begin
        int exp_ord [4];
        exp_ord = '{0, 1, 0, 1};
        rst = 1'b1;
        repeat (2) @(posedge clk_100M);
        @(negedge clk_100M);

        // Single op 3*3 from requester 0
        run(1, 0, 1, 3, 3, 0, 0, 0, 1, 1);
        run(4, 0, 0, 0, 0, 0, 0, 0, 1, 1);

        // Requester 1 15*15, then requester 0 15*7
        run(1, 0, 0, 0, 0, 1, 15, 15, 1, 1);
        run(4, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        run(1, 0, 1, 15, 7, 0, 0, 0, 1, 1);
        run(4, 0, 0, 0, 0, 0, 0, 0, 1, 1);

        // Both continuously valid after reset: grants alternate
        run(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        gq.delete();
        run(4 * (LAT + 3), 0, 1, 4, 3, 1, 7, 7, 1, 1);
        chk("grant_count", gq.size(), 4);
        for (int i = 0; i < 4 && i < gq.size(); i++)
            chk($sformatf("grant_order[%0d]", i), gq[i], exp_ord[i]);
        run(2, 0, 0, 0, 0, 0, 0, 0, 1, 1);

        // Backpressure on response 0 while requester 1 keeps asking
        run(1, 0, 1, 1, 1, 0, 0, 0, 0, 0);
        run(7, 0, 0, 0, 0, 1, 2, 2, 0, 0);
        run(6, 0, 0, 0, 0, 0, 0, 0, 1, 1);

        // Reset during WAIT abandons the op; re-issue afterwards
        run(1, 0, 1, 1, 7, 0, 0, 0, 1, 1);
        run(1, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        run(1, 1, 0, 0, 0, 0, 0, 0, 1, 1);
        run(2, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        run(1, 0, 1, 1, 7, 0, 0, 0, 1, 1);
        run(4, 0, 0, 0, 0, 0, 0, 0, 1, 1);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 99) == 0),
                 ($urandom_range(0, 2) != 0), 4'($urandom), 4'($urandom),
                 ($urandom_range(0, 2) != 0), 4'($urandom), 4'($urandom),
                 ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
